matmul_engine: RTL and testbench



---
 rtl/matmul_pkg.sv | 27 ++
 rtl/mac_unit.sv | 44 ++++
 rtl/matmul_engine.sv | 134 +++++++++++++
 tb/tb_matmul_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package matmul_pkg;

  localparam int DEF_N = 2;
  localparam int DEF_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    ACC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int b = 0; b < 32; b++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Unsigned W x W multiply feeding a CW-bit accumulator register.
// Latency: product is folded into acc_o on the edge where en_i is high.
// Backpressure: none; clr_i has priority over en_i.
module mac_unit #(
  parameter int W  = 8,
  parameter int CW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  output logic [CW-1:0] acc_o
);

  logic [2*W-1:0] prod;
  logic [CW-1:0]  acc_q;
  logic [CW-1:0]  acc_d;

  assign prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

  // Next accumulator value: clear wins, otherwise add the zero-extended product.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + CW'(prod);
    end
  end

  // Accumulator register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matmul_engine.sv
// Sequencer computing C = A x B for N x N unsigned matrices held in memories.
// Latency: each C element takes 2N+1 cycles; done pulses one cycle after the last write.
// Backpressure: none; memories are assumed to accept every strobe, start is ignored while busy.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int AW = 6,
  parameter int CW = 2 * W + clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en_a,
  output logic [AW-1:0] rd_addr_a,
  input  logic [W-1:0]  rd_data_a,
  output logic          rd_en_b,
  output logic [AW-1:0] rd_addr_b,
  input  logic [W-1:0]  rd_data_b,
  output logic          wr_en_c,
  output logic [AW-1:0] wr_addr_c,
  output logic [CW-1:0] wr_data_c
);

  // Index counters need at least one bit even for degenerate N.
  localparam int IW = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] k_q, k_d;
  logic          mac_clr;
  logic          mac_en;
  logic [CW-1:0] acc;

  mac_unit #(
    .W  (W),
    .CW (CW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (rd_data_a),
    .b_i   (rd_data_b),
    .acc_o (acc)
  );

  // Next-state and counter logic; the accumulator is steered through mac_clr/mac_en.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        state_d = ACC;
      end
      ACC: begin
        // Read data from the READ cycle is valid now.
        mac_en = 1'b1;
        if (k_q == LAST) begin
          state_d = WRITE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = READ;
        end
      end
      WRITE: begin
        mac_clr = 1'b1;
        k_d     = '0;
        if (i_q == LAST && j_q == LAST) begin
          state_d = DONE;
        end else begin
          if (j_q == LAST) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
          state_d = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and index registers; reset returns to IDLE with zeroed counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Moore outputs decoded from registered state and counters.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign rd_en_a   = (state_q == READ);
  assign rd_en_b   = (state_q == READ);
  assign wr_en_c   = (state_q == WRITE);
  assign rd_addr_a = AW'(i_q) * AW'(N) + AW'(k_q);
  assign rd_addr_b = AW'(k_q) * AW'(N) + AW'(j_q);
  assign wr_addr_c = AW'(i_q) * AW'(N) + AW'(j_q);
  assign wr_data_c = acc;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine with behavioural A/B/C memories.
// Latency: cycle numbers are counted from the edge that samples start (cycle 1 follows it).
// Backpressure: n/a.
module tb_matmul_engine;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int AW = 6;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          rd_en_a;
  logic [AW-1:0] rd_addr_a;
  logic [W-1:0]  rd_data_a;
  logic          rd_en_b;
  logic [AW-1:0] rd_addr_b;
  logic [W-1:0]  rd_data_b;
  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic [CW-1:0] wr_data_c;

  matmul_engine #(
    .N  (N),
    .W  (W),
    .AW (AW),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en_a   (rd_en_a),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_en_b   (rd_en_b),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_en_c   (wr_en_c),
    .wr_addr_c (wr_addr_c),
    .wr_data_c (wr_data_c)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;

  // Free-running edge counter used to timestamp events.
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] mem_a [64];
  logic [W-1:0] mem_b [64];
  int           exp_c [4];

  // Registered-read memories: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
  end

  int q_addr[$];
  int q_data[$];
  int q_cyc[$];
  int done_cnt = 0;
  int done_cyc = -1;
  int busy_cnt = 0;

  // Observe outputs mid-cycle and log writes, done pulses and busy cycles.
  always @(negedge clk) begin
    if (wr_en_c) begin
      q_addr.push_back(int'(wr_addr_c));
      q_data.push_back(int'(wr_data_c));
      q_cyc.push_back(cyc - base);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc - base;
    end
    if (busy) busy_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq({tag, "_busy"},  32'(busy), 0);
    check_eq({tag, "_done"},  32'(done), 0);
    check_eq({tag, "_rd_a"},  32'(rd_en_a), 0);
    check_eq({tag, "_rd_b"},  32'(rd_en_b), 0);
    check_eq({tag, "_wr_c"},  32'(wr_en_c), 0);
    check_eq({tag, "_addrs"}, 32'({rd_addr_a, rd_addr_b, wr_addr_c}), 0);
    check_eq({tag, "_wdata"}, 32'(wr_data_c), 0);
  endtask

  task automatic load(input int a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3);
    mem_a[0] = W'(a0); mem_a[1] = W'(a1); mem_a[2] = W'(a2); mem_a[3] = W'(a3);
    mem_b[0] = W'(b0); mem_b[1] = W'(b1); mem_b[2] = W'(b2); mem_b[3] = W'(b3);
    exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2; exp_c[3] = c3;
  endtask

  // One bounded run: start pulsed (or held until hold_until), optional extra start
  // pulse at restart_at, optional reset held for two cycles from rst_at.
  task automatic run(input int restart_at, input int rst_at, input int hold_until, input int max_cyc);
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    @(negedge clk);
    #1;
    done_cnt = 0;
    done_cyc = -1;
    busy_cnt = 0;
    base     = cyc;
    start    = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      #1;
      if (hold_until == 0) start = (c == restart_at);
      else if (c >= hold_until) start = 1'b0;
      if (rst_at != 0 && c == rst_at) begin
        rst = 1'b0;
        #1;
        check_outs_zero("midrst");
      end
      if (rst_at != 0 && c == rst_at + 2) rst = 1'b1;
    end
    start = 1'b0;
  endtask

  // Four writes starting at queue index first, expected in cycles off+5, off+10, ...
  task automatic check_writes(input string tag, input int first, input int off);
    for (int e = 0; e < 4; e++) begin
      if (first + e < q_addr.size()) begin
        check_eq($sformatf("%s_w%0d_addr", tag, e), 32'(q_addr[first+e]), 32'(e));
        check_eq($sformatf("%s_w%0d_data", tag, e), 32'(q_data[first+e]), 32'(exp_c[e]));
        check_eq($sformatf("%s_w%0d_cyc",  tag, e), 32'(q_cyc[first+e]),  32'(off + 5 + 5 * e));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_outs_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic product: [1 2;3 4] x [5 6;7 8] = [19 22;43 50].
    load(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
    run(0, 0, 0, 28);
    check_eq("basic_nwr", 32'(q_addr.size()), 4);
    check_writes("basic", 0, 0);
    check_eq("basic_done_cnt", 32'(done_cnt), 1);
    check_eq("basic_done_cyc", 32'(done_cyc), 21);
    check_eq("basic_busy_cyc", 32'(busy_cnt), 21);
    check_eq("basic_idle", 32'(busy), 0);

    // Identity x [9 8;7 6].
    load(1, 0, 0, 1, 9, 8, 7, 6, 9, 8, 7, 6);
    run(0, 0, 0, 25);
    check_eq("ident_nwr", 32'(q_addr.size()), 4);
    check_writes("ident", 0, 0);
    check_eq("ident_done_cnt", 32'(done_cnt), 1);

    // All 255: each element 2*255*255 = 130050.
    load(255, 255, 255, 255, 255, 255, 255, 255, 130050, 130050, 130050, 130050);
    run(0, 0, 0, 25);
    check_eq("max_nwr", 32'(q_addr.size()), 4);
    check_writes("max", 0, 0);

    // Extra start pulse in cycle 7 is ignored.
    load(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
    run(7, 0, 0, 28);
    check_eq("busystart_nwr", 32'(q_addr.size()), 4);
    check_writes("busystart", 0, 0);
    check_eq("busystart_done_cnt", 32'(done_cnt), 1);
    check_eq("busystart_done_cyc", 32'(done_cyc), 21);
    check_eq("busystart_busy_cyc", 32'(busy_cnt), 21);

    // Reset in cycle 12: only the writes of cycles 5 and 10 happen, no done.
    run(0, 12, 0, 25);
    check_eq("midrst_nwr", 32'(q_addr.size()), 2);
    check_eq("midrst_done_cnt", 32'(done_cnt), 0);
    check_eq("midrst_idle", 32'(busy), 0);
    run(0, 0, 0, 25);
    check_eq("afterrst_nwr", 32'(q_addr.size()), 4);
    check_writes("afterrst", 0, 0);
    check_eq("afterrst_done_cyc", 32'(done_cyc), 21);

    // Start held high: second run begins with cycle 23 as its cycle 1.
    run(0, 0, 30, 50);
    check_eq("b2b_nwr", 32'(q_addr.size()), 8);
    check_writes("b2b_run1", 0, 0);
    check_writes("b2b_run2", 4, 22);
    check_eq("b2b_done_cnt", 32'(done_cnt), 2);
    check_eq("b2b_done_cyc", 32'(done_cyc), 43);
    check_eq("b2b_busy_cyc", 32'(busy_cnt), 42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
